// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default link parameters
// common to the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // 50 MHz system clock at 115200 baud, 8N1.
  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit; the reset value
// is a parameter so idle-high lines come out of reset in their idle state.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_p0 <= RST_VAL;
      q       <= RST_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: mid-bit sampling of a synchronised serial line, LSB-first
// deserialisation, single-cycle valid / frame-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev;
  rx_state_e            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n;
  logic                 ferr_n;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d    (rx_i),
    .q    (rx_s)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    data_n    = data_o;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    if (en_i) begin
      cnt_n = cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          // Only a 1->0 transition starts a frame, so a held-low break is ignored.
          if (rx_prev && !rx_s) state_n = START;
        end
        START: begin
          if (cnt == HALF_LAST) state_n = rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) state_n = STOP;
            else                     bit_cnt_n = bit_cnt + 1'b1;
          end
        end
        STOP: begin
          // Returning to IDLE at stop mid-bit leaves half a bit to catch the next start edge.
          if (cnt == FULL_LAST) begin
            state_n = IDLE;
            if (rx_s) begin
              data_n  = shreg;
              valid_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
      if (state_n != state) cnt_n = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      rx_prev     <= 1'b1;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_cnt     <= bit_cnt_n;
      rx_prev     <= rx_s;
      data_o      <= data_n;
      valid_o     <= valid_n;
      frame_err_o <= ferr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    shreg <= shreg_n;
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and randomised frames against a timing model that
// predicts every pulse, busy window and data_o value from the frame schedule.
module tb_uart_rx;

  localparam int C = 16;
  localparam int D = 8;
  localparam int H = C / 2;

  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_FERR  = 2;
  localparam int K_RST   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rx;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (D)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .rx_i       (rx),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
  );

  typedef struct {
    int         busy_from;
    int         pulse_at;
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         chk_on = 1'b0;
  logic [7:0] exp_data = 8'h00;
  bit         exp_v, exp_f, exp_b;
  int         valid_cnt = 0;
  int         last_valid_cyc = 0;
  int         prev_valid_cyc = 0;
  logic [7:0] last_valid_data = 8'h00;
  int         busy_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Cycle-by-cycle comparison against the frame schedule.
  initial forever begin
    @(negedge clk);
    if (busy_o) busy_cycles++;
    if (valid_o) begin
      valid_cnt++;
      prev_valid_cyc  = last_valid_cyc;
      last_valid_cyc  = cyc;
      last_valid_data = data_o;
    end
    if (chk_on) begin
      exp_v = 1'b0;
      exp_f = 1'b0;
      exp_b = 1'b0;
      if (evq.size() > 0) begin
        if (cyc >= evq[0].busy_from && cyc < evq[0].pulse_at) exp_b = 1'b1;
        if (cyc == evq[0].pulse_at) begin
          case (evq[0].kind)
            K_VALID: begin exp_v = 1'b1; exp_data = evq[0].data; end
            K_FERR:  exp_f = 1'b1;
            K_RST:   exp_data = 8'h00;
            default: ;
          endcase
          evq.delete(0);
        end
      end
      check("valid_o", 32'(valid_o), 32'(exp_v));
      check("frame_err_o", 32'(frame_err_o), 32'(exp_f));
      check("busy_o", 32'(busy_o), 32'(exp_b));
      check("data_o", 32'(data_o), 32'(exp_data));
    end
  end

  // All drive tasks start and end on a falling clock edge.
  task automatic idle(input int k);
    rx = 1'b1;
    repeat (k) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int pause_bit,
                            input int pause_len, input int abort_bit);
    ev_t e;
    int  n;
    int  extra;
    n     = cyc;
    extra = (pause_bit >= 0) ? pause_len : 0;
    e.busy_from = n + 3;
    e.data      = d;
    if (abort_bit >= 0) begin
      e.kind     = K_RST;
      e.pulse_at = n + (abort_bit + 1) * C + C / 2 + 1;
    end else begin
      e.kind     = stop_b ? K_VALID : K_FERR;
      e.pulse_at = n + 2 + H + (D + 1) * C + 1 + extra;
    end
    evq.push_back(e);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int b = 0; b < D; b++) begin
      rx = d[b];
      if (b == abort_bit) begin
        repeat (C / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (b == pause_bit) begin
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (pause_len) @(negedge clk);
        en = 1'b1;
        repeat (C - 4) @(negedge clk);
      end else begin
        repeat (C) @(negedge clk);
      end
    end
    rx = stop_b;
    repeat (C) @(negedge clk);
  endtask

  task automatic glitch(input int len);
    ev_t e;
    e.busy_from = cyc + 3;
    e.pulse_at  = cyc + 2 + H + 1;
    e.kind      = K_NONE;
    e.data      = 8'h00;
    evq.push_back(e);
    rx = 1'b0;
    repeat (len) @(negedge clk);
    rx = 1'b1;
    repeat (C) @(negedge clk);
  endtask

  initial begin
    int         n;
    int         v;
    int         sel;
    int         gap;
    logic [7:0] d;
    rst = 1'b1;
    en  = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data_o), 32'h0);
    check("reset_valid", 32'(valid_o), 32'h0);
    check("reset_ferr", 32'(frame_err_o), 32'h0);
    check("reset_busy", 32'(busy_o), 32'h0);
    rst    = 1'b0;
    chk_on = 1'b1;
    idle(5);

    n = cyc;
    send_frame(8'hA5, 1'b1, -1, 0, -1);
    idle(C);
    check("a5_latency", 32'(last_valid_cyc - (n + 2)), 32'd153);
    check("a5_data", 32'(last_valid_data), 32'hA5);

    busy_cycles = 0;
    glitch(4);
    check("glitch_busy_cycles", 32'(busy_cycles), 32'd8);

    v = valid_cnt;
    send_frame(8'h3C, 1'b0, -1, 0, -1);
    repeat (3 * C) @(negedge clk);
    check("ferr_keeps_data", 32'(data_o), 32'hA5);
    check("ferr_no_valid", 32'(valid_cnt), 32'(v));
    idle(C);

    send_frame(8'h00, 1'b1, -1, 0, -1);
    send_frame(8'hFF, 1'b1, -1, 0, -1);
    idle(C);
    check("b2b_gap", 32'(last_valid_cyc - prev_valid_cyc), 32'd160);
    check("b2b_data", 32'(last_valid_data), 32'hFF);

    n = cyc;
    send_frame(8'h5A, 1'b1, 3, 20, -1);
    idle(C);
    check("pause_latency", 32'(last_valid_cyc - (n + 2)), 32'd173);
    check("pause_data", 32'(last_valid_data), 32'h5A);

    v = valid_cnt;
    send_frame(8'hC3, 1'b1, -1, 0, 5);
    idle(C);
    check("abort_no_pulse", 32'(valid_cnt), 32'(v));
    send_frame(8'h81, 1'b1, -1, 0, -1);
    idle(C);
    check("after_abort_data", 32'(last_valid_data), 32'h81);

    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        glitch(int'($urandom_range(1, 6)));
      end else begin
        d = 8'($urandom);
        if (sel == 2)
          send_frame(d, 1'b1, int'($urandom_range(0, D - 1)), int'($urandom_range(1, 30)), -1);
        else
          send_frame(d, (sel != 1), -1, 0, -1);
        gap = (sel == 1) ? int'($urandom_range(1, 20)) : int'($urandom_range(0, 20));
        idle(gap);
      end
    end

    idle(2 * C);
    check("queue_drained", 32'(evq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
